// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC, in-order imem requests, prefetch FIFO, redirect squash.
// Optional stall counter output enabled by defining IFU_STALL_CNT_EN.
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     iq_wr_q, iq_wr_d;
    logic [PW-1:0]     iq_rd_q, iq_rd_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [ADDR_W-1:0] iq_pc_q [DEPTH];
    logic [ADDR_W-1:0] iq_pc_d [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_d [DEPTH];
    logic [31:0]       fifo_data_q [DEPTH];
    logic [31:0]       fifo_data_d [DEPTH];

    logic credit;
    logic req_fire;
    logic rsp_keep;
    logic consume;
    logic unused_rpc;

    // Credits count both in-flight responses and buffered words.
    assign credit = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_W;

    assign imem_req_valid = rst_n && credit && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = (count_q != '0);
    assign consume     = instr_valid && instr_ready && !redirect_valid;
    assign rsp_keep    = imem_rsp_valid && (discard_q == '0) && !redirect_valid;

    assign instruction = instr_valid ? fifo_data_q[head_q] : '0;
    assign instr_pc    = instr_valid ? fifo_pc_q[head_q] : RESET_PC;

    assign unused_rpc = ^redirect_pc[1:0];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        iq_wr_d       = iq_wr_q;
        iq_rd_d       = iq_rd_q;
        head_d        = head_q;
        tail_d        = tail_q;
        iq_pc_d       = iq_pc_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_data_d   = fifo_data_q;

        if (req_fire) begin
            iq_pc_d[iq_wr_q] = fetch_pc_q;
            iq_wr_d          = iq_wr_q + PW'(1);
            fetch_pc_d       = fetch_pc_q + ADDR_W'(4);
        end

        if (imem_rsp_valid) begin
            iq_rd_d = iq_rd_q + PW'(1);
        end

        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (rsp_keep) begin
            fifo_pc_d[tail_q]   = iq_pc_q[iq_rd_q];
            fifo_data_d[tail_q] = imem_rsp_data;
            tail_d              = tail_q + PW'(1);
        end

        if (consume) begin
            head_d = head_q + PW'(1);
        end

        count_d = count_q + CW'(rsp_keep) - CW'(consume);

        if (imem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            discard_d  = outstanding_q - CW'(imem_rsp_valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            iq_wr_q       <= '0;
            iq_rd_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                iq_pc_q[i]     <= '0;
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            iq_wr_q       <= iq_wr_d;
            iq_rd_q       <= iq_rd_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            iq_pc_q       <= iq_pc_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_data_q   <= fifo_data_d;
        end
    end

`ifdef IFU_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (instr_ready && !instr_valid && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
